cpu_host_ctrl: RTL
==================

# cpu_host_ctrl

Host-side sequencer for the 8-bit CPU core. Accepts a 16-bit command stream from a host (valid/ready), loads instruction RAM and data RAM, launches the CPU via its `start`/`idle` handshake, and reports the run's cycle count. It also streams data RAM contents back to the host. It owns the data RAM port whenever the CPU is not running and muxes the CPU's port onto it during a run.

## Interface
Parameters
- CNT_W, 16, width of run cycle counter (saturating, ≤16)

Ports
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_valid  in  1  host command/data word valid
- s_ready  out  1  block accepts s_data this cycle
- s_data  in  16  host word
- m_valid  out  1  response word valid
- m_ready  in  1  host accepts m_data
- m_data  out  16  response word
- err  out  1  sticky bad-opcode flag; cleared by next accepted valid header
- cpu_start  out  1  one-cycle start pulse to CPU
- cpu_idle  in  1  CPU idle status
- iram_we  out  1  IRAM write enable
- iram_waddr  out  8  IRAM write address
- iram_wdata  out  16  IRAM write data
- cpu_dram_addr / cpu_dram_din / cpu_dram_write  in  8/8/1  CPU data-RAM port
- mem_dram_addr / mem_dram_din / mem_dram_write  out  8/8/1  to data RAM
- mem_dram_dout  in  8  data RAM read data, synchronous, 1-cycle latency

## Operation
- Command = two header words then payload. H0 = {op[3:0], 4'b0, len_m1[7:0]}; H1 = {8'b0, base[7:0]}. Word count N = len_m1+1 (1..256).
- op 1 LOAD_I: N payload words, word k → IRAM[(base+k) mod 256].
- op 2 LOAD_D: N payload words, low byte k → DRAM[(base+k) mod 256]; high byte ignored.
- op 3 RUN: no payload, len/base ignored. Pulse cpu_start, count cycles until cpu_idle, emit one response word = count.
- op 4 READ_D: emit N response words {8'b0, DRAM[(base+k) mod 256]}.
- Other op: H1 still consumed, no action, err=1, back to IDLE.
- States: IDLE (await H0) → HDR1 → LOAD_I | LOAD_D | RUN_GO | RD_ADDR | IDLE.
  - LOAD_I/LOAD_D: s_ready=1; each handshake writes one word, address+1; after Nth word → IDLE.
  - RUN_GO: cpu_start=1 one cycle, counter cleared to 0 → RUN_WAIT.
  - RUN_WAIT: s_ready=0; counter +1 per cycle, saturates at 2^CNT_W−1; when cpu_idle=1 → RUN_RSP.
  - RUN_RSP: m_valid=1, m_data=count; on m_ready → IDLE.
  - RD_ADDR: drive address (1 cycle) → RD_DATA: capture mem_dram_dout into output reg, m_valid=1, hold until m_ready; then next address or IDLE after Nth.
- DRAM mux: in RUN_GO/RUN_WAIT mem_dram_* = cpu_dram_*; otherwise block drives them, mem_dram_write=1 only on LOAD_D handshake.
- s_ready=1 only in IDLE, HDR1, LOAD_I, LOAD_D. m_valid only in RUN_RSP, RD_DATA. iram_we only on LOAD_I handshake.

## Timing
- Reset values: state IDLE, s_ready=0 while rst high (1 in first IDLE cycle after release), m_valid=0, m_data=0, err=0, cpu_start=0, iram_we=0, mem_dram_write=0, addresses/data 0, counter 0.
- Writes are combinational from the accepting handshake: iram_we/mem_dram_write high in the same cycle as s_valid&s_ready.
- cpu_start high exactly one cycle; CPU's idle falls the following cycle, so RUN_WAIT's first cycle already sees cpu_idle=0. Count = cycles spent in RUN_WAIT (includes the cycle idle is seen high? no: excludes it).
- READ_D throughput: one word per 2 cycles with m_ready held high; m_data/m_valid stable while m_ready=0.
- Address wraps 255→0 inside a command.
- s_valid during RUN_WAIT/RUN_RSP/RD_*: ignored, word not consumed.
- rst mid-command: immediate return to reset values; partial loads left in RAM; CPU not affected by this block beyond start deassertion.

## Test plan
- LOAD_I len_m1=2 base=0x10, payload 0x1234,0x5678,0x9ABC → IRAM[0x10..0x12] written in 3 consecutive handshake cycles, iram_we 3 pulses, back to IDLE.
- LOAD_D len_m1=1 base=0xFF, payload 0x00AA,0x00BB → DRAM[0xFF]=0xAA, DRAM[0x00]=0xBB (wrap).
- RUN with CPU model holding idle low 10 cycles → single cpu_start pulse, one response word 10, DRAM port follows CPU during run.
- READ_D len_m1=3 base=0 with m_ready toggling 1/0 → 4 words 0x00xx matching DRAM, m_data stable while stalled, m_valid never dropped mid-word.
- Header op=0xF → H1 consumed, err=1, no writes; next valid LOAD_D header clears err.
- Assert rst during LOAD_D after 2 of 4 words → all outputs reset immediately; new LOAD_D after release completes normally.

Source files
------------

// File: rtl/cpu_host_ctrl.sv
// cpu_host_ctrl: host command sequencer for the 8-bit CPU.
// Loads IRAM/DRAM, launches runs, times them, and streams DRAM back.
module cpu_host_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        err,
  output logic        cpu_start,
  input  logic        cpu_idle,
  output logic        iram_we,
  output logic [7:0]  iram_waddr,
  output logic [15:0] iram_wdata,
  input  logic [7:0]  cpu_dram_addr,
  input  logic [7:0]  cpu_dram_din,
  input  logic        cpu_dram_write,
  output logic [7:0]  mem_dram_addr,
  output logic [7:0]  mem_dram_din,
  output logic        mem_dram_write,
  input  logic [7:0]  mem_dram_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_LOAD_I, S_LOAD_D,
    S_RUN_GO, S_RUN_WAIT, S_RUN_RSP,
    S_RD_ADDR, S_RD_DATA
  } state_t;

  localparam logic [3:0] OP_LI  = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_RUN = 4'd3;
  localparam logic [3:0] OP_RD  = 4'd4;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mdat_q, mdat_d;
  logic             err_q, err_d;
  logic             first_q, first_d;

  logic s_hs;
  logic last;
  logic cpu_own;
  logic op_ok;

  assign s_ready = !rst && (state_q == S_IDLE || state_q == S_HDR1 ||
                            state_q == S_LOAD_I || state_q == S_LOAD_D);
  assign s_hs    = s_valid && s_ready;
  assign last    = (idx_q == len_q);
  assign cpu_own = (state_q == S_RUN_GO) || (state_q == S_RUN_WAIT);
  assign op_ok   = (s_data[15:12] >= OP_LI) && (s_data[15:12] <= OP_RD);

  assign m_valid   = (state_q == S_RUN_RSP) || (state_q == S_RD_DATA);
  assign m_data    = (state_q == S_RD_DATA && first_q) ?
                     {8'h00, mem_dram_dout} : mdat_q;
  assign err       = err_q;
  assign cpu_start = (state_q == S_RUN_GO);

  assign iram_we    = s_hs && (state_q == S_LOAD_I);
  assign iram_waddr = addr_q;
  assign iram_wdata = (state_q == S_LOAD_I) ? s_data : 16'h0000;

  assign mem_dram_addr  = cpu_own ? cpu_dram_addr : addr_q;
  assign mem_dram_din   = cpu_own ? cpu_dram_din :
                          ((state_q == S_LOAD_D) ? s_data[7:0] : 8'h00);
  assign mem_dram_write = cpu_own ? cpu_dram_write :
                          (s_hs && state_q == S_LOAD_D);

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mdat_d  = mdat_q;
    err_d   = err_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s_hs) begin
          op_d    = s_data[15:12];
          len_d   = s_data[7:0];
          if (op_ok) err_d = 1'b0;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (s_hs) begin
          addr_d = s_data[7:0];
          idx_d  = 8'd0;
          case (op_q)
            OP_LI:   state_d = S_LOAD_I;
            OP_LD:   state_d = S_LOAD_D;
            OP_RUN:  state_d = S_RUN_GO;
            OP_RD:   state_d = S_RD_ADDR;
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_LOAD_I, S_LOAD_D: begin
        if (s_hs) begin
          addr_d = addr_q + 8'd1;
          idx_d  = idx_q + 8'd1;
          if (last) state_d = S_IDLE;
        end
      end
      S_RUN_GO: begin
        cnt_d   = '0;
        state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (cpu_idle) begin
          mdat_d  = 16'(cnt_q);
          state_d = S_RUN_RSP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN_RSP: begin
        if (m_ready) state_d = S_IDLE;
      end
      S_RD_ADDR: begin
        first_d = 1'b1;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (first_q) mdat_d = {8'h00, mem_dram_dout};
        if (m_ready) begin
          if (last) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            addr_d  = addr_q + 8'd1;
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      addr_q  <= 8'd0;
      cnt_q   <= '0;
      mdat_q  <= 16'h0000;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mdat_q  <= mdat_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

endmodule
